// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access front end: request op field
// layout, access size encodings, FSM state encoding and small helpers for
// size normalisation and sub-word alignment.
package mem_access_pkg;

  // req_op = {store, unsigned, size[1:0]}
  localparam int OP_STORE   = 3;
  localparam int OP_UNS     = 2;
  localparam int OP_SIZE_HI = 1;
  localparam int OP_SIZE_LO = 0;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CAP  = 2'd2,
    ST_WR   = 2'd3
  } state_e;

  // Size 11 has no meaning of its own and behaves as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    return (sz == 2'b11) ? SZ_WORD : sz;
  endfunction

  // Clears the low address bits that a half or word access cannot use.
  function automatic logic [1:0] align_offset(input logic [1:0] sz,
                                              input logic [1:0] off);
    case (sz)
      SZ_BYTE: return off;
      SZ_HALF: return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  // True when the low address bits do not match the access size.
  function automatic logic misaligned(input logic [1:0] sz,
                                      input logic [1:0] off);
    return ((sz == SZ_HALF) && off[0]) || ((sz == SZ_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational big-endian lane steering between a 32-bit memory word and
// right-aligned register data. Load side extracts the addressed byte/half
// and sign- or zero-extends it; store side merges the low byte/half of the
// write data into the addressed lane of the current memory word.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] mem_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  function automatic logic signed [31:0] ext8(input logic [7:0] b, input logic zx);
    logic signed [7:0] sb;
    sb = b;
    return zx ? $signed({24'h0, b}) : 32'(sb);
  endfunction

  function automatic logic signed [31:0] ext16(input logic [15:0] h, input logic zx);
    logic signed [15:0] sh;
    sh = h;
    return zx ? $signed({16'h0, h}) : 32'(sh);
  endfunction

  // Pick the addressed lane; offset 0 is the most significant byte.
  always_comb begin
    byte_lane = mem_word[31:24];
    case (offset)
      2'd0: byte_lane = mem_word[31:24];
      2'd1: byte_lane = mem_word[23:16];
      2'd2: byte_lane = mem_word[15:8];
      2'd3: byte_lane = mem_word[7:0];
      default: byte_lane = mem_word[31:24];
    endcase
    half_lane = offset[1] ? mem_word[15:0] : mem_word[31:16];
  end

  // Extend the extracted lane to a full register value.
  always_comb begin
    case (size)
      SZ_BYTE: load_data = ext8(byte_lane, uns);
      SZ_HALF: load_data = ext16(half_lane, uns);
      default: load_data = mem_word;
    endcase
  end

  // Overlay the store data onto the addressed lane, keeping other lanes.
  always_comb begin
    merge_data = mem_word;
    case (size)
      SZ_BYTE: begin
        case (offset)
          2'd0: merge_data[31:24] = wdata[7:0];
          2'd1: merge_data[23:16] = wdata[7:0];
          2'd2: merge_data[15:8]  = wdata[7:0];
          2'd3: merge_data[7:0]   = wdata[7:0];
          default: merge_data = mem_word;
        endcase
      end
      SZ_HALF: begin
        if (offset[1]) merge_data[15:0]  = wdata[15:0];
        else           merge_data[31:16] = wdata[15:0];
      end
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end in front of a word-only synchronous data memory.
// Word stores write directly; byte/half stores do read-modify-write; loads
// read, extract the lane and extend. Each transaction ends with a one-cycle
// rsp_valid pulse.
// Optional build macro MEM_ACCESS_MISALIGN_TRAP_EN: misaligned half/word
// accesses complete immediately with rsp_err instead of being force-aligned.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  state_e            state_q, state_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_d;

  // Latched request fields (data path, not reset).
  logic              store_q, store_d;
  logic              uns_q, uns_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              accept;
  logic              req_store;
  logic [1:0]        req_size;
  logic [1:0]        req_off;
  logic [31:0]       load_data;
  logic [31:0]       merge_data;
  logic              unused_addr_hi;

  assign req_ready      = (state_q == ST_IDLE);
  assign accept         = req_valid && req_ready;
  assign req_store      = req_op[OP_STORE];
  assign req_size       = norm_size(req_op[OP_SIZE_HI:OP_SIZE_LO]);
  assign req_off        = align_offset(req_size, req_addr[1:0]);
  assign unused_addr_hi = ^req_addr[31:MEM_AW+2];

  mem_lane_align u_lane_align (
    .offset     (off_q),
    .size       (size_q),
    .uns        (uns_q),
    .mem_word   (mem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = 1'b0;
    store_d     = store_q;
    uns_d       = uns_q;
    size_d      = size_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          store_d = req_store;
          uns_d   = req_op[OP_UNS];
          size_d  = req_size;
          off_d   = req_off;
          wdata_d = req_wdata;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
          if (misaligned(req_size, req_addr[1:0])) begin
            // Trap: answer at once, never touch memory.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else
`endif
          begin
            mem_addr_d = req_addr[MEM_AW+1:2];
            if (req_store && (req_size == SZ_WORD)) begin
              // Full-word store needs no read.
              mem_wdata_d = req_wdata;
              mem_we_d    = 1'b1;
              state_d     = ST_WR;
            end else begin
              state_d = ST_RD;
            end
          end
        end
      end
      ST_RD: begin
        state_d = ST_CAP;
      end
      ST_CAP: begin
        if (store_q) begin
          mem_wdata_d = merge_data;
          mem_we_d    = 1'b1;
          state_d     = ST_WR;
        end else begin
          rsp_rdata_d = load_data;
          rsp_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_WR: begin
        rsp_rdata_d = 32'h0;
        rsp_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs; reset aborts any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      mem_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Request capture register; only meaningful while a transaction runs.
  always_ff @(posedge clk) begin
    store_q <= store_d;
    uns_q   <= uns_d;
    size_q  <= size_d;
    off_q   <= off_d;
    wdata_q <= wdata_d;
  end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic rsp_err_q;

  // Error flag accompanies the trap response pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_err_q <= 1'b0;
    else        rsp_err_q <= rsp_err_d;
  end

  assign rsp_err = rsp_err_q;
`else
  logic unused_err;
  assign unused_err = rsp_err_d;
  assign rsp_err    = 1'b0;
`endif

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a synchronous word memory model.
module tb_mem_access_unit;

  localparam int MEM_AW = 8;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LW3 = 4'b0011;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_LWU = 4'b0110;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;
  localparam logic [3:0] OP_SBU = 4'b1100;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic [31:0]       mem_rdata;

  logic              pre_we;
  logic [MEM_AW-1:0] pre_addr;
  logic [31:0]       pre_data;
  logic [31:0]       mem [0:(1<<MEM_AW)-1];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_we;
    int          widx;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_AW(MEM_AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  // Word-only synchronous memory: read data one cycle after the address.
  always @(posedge clk) begin
    if (pre_we)      mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int idx, input logic [31:0] data);
    pre_we   = 1'b1;
    pre_addr = MEM_AW'(idx);
    pre_data = data;
    step();
    pre_we   = 1'b0;
  endtask

  task automatic add(input string name, input logic [3:0] op, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err,
                     input int exp_lat, input int exp_we, input int widx, input logic [31:0] exp_word);
    vec_t v;
    v.name = name; v.op = op; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    v.exp_we = exp_we; v.widx = widx; v.exp_word = exp_word;
    vecs.push_back(v);
  endtask

  // Issue one request and follow it to its response (bounded).
  task automatic run_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int we_cnt, output logic pulse_after);
    lat = -1; we_cnt = 0; rdata = 32'h0; err = 1'b0;
    for (int w = 0; w < 20 && !req_ready; w++) step();
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    step();
    req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (mem_we) we_cnt++;
      if (rsp_valid) begin
        lat = k; rdata = rsp_rdata; err = rsp_err;
        break;
      end
      step();
    end
    step();
    pulse_after = rsp_valid;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          wec;
    logic        pa;
    logic        seen_we;
    logic        seen_rsp;

    rst_n = 1'b0; req_valid = 1'b0; req_op = 4'h0; req_addr = 32'h0; req_wdata = 32'h0;
    pre_we = 1'b0; pre_addr = '0; pre_data = 32'h0;

    // Reset state
    repeat (3) step();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err",   32'(rsp_err), 32'd0);
    check("rst_mem_addr",  32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_we",    32'(mem_we), 32'd0);
    rst_n = 1'b1;
    step();

    preload(4, 32'h11223344);
    preload(8, 32'h80FF7F01);
    preload(17, 32'h00000000);

    add("lw_10",   OP_LW,  32'h10, 32'h0, 32'h11223344, 1'b0, 3, 0, 4, 32'h11223344);
    add("lb_20",   OP_LB,  32'h20, 32'h0, 32'hFFFFFF80, 1'b0, 3, 0, 8, 32'h80FF7F01);
    add("lbu_20",  OP_LBU, 32'h20, 32'h0, 32'h00000080, 1'b0, 3, 0, 8, 32'h80FF7F01);
    add("lh_20",   OP_LH,  32'h20, 32'h0, 32'hFFFF80FF, 1'b0, 3, 0, 8, 32'h80FF7F01);
    add("lhu_22",  OP_LHU, 32'h22, 32'h0, 32'h00007F01, 1'b0, 3, 0, 8, 32'h80FF7F01);
    add("lb_21",   OP_LB,  32'h21, 32'h0, 32'hFFFFFFFF, 1'b0, 3, 0, 8, 32'h80FF7F01);
    add("lbu_22",  OP_LBU, 32'h22, 32'h0, 32'h0000007F, 1'b0, 3, 0, 8, 32'h80FF7F01);
    add("lb_23",   OP_LB,  32'h23, 32'h0, 32'h00000001, 1'b0, 3, 0, 8, 32'h80FF7F01);
    add("lh_22",   OP_LH,  32'h22, 32'h0, 32'h00007F01, 1'b0, 3, 0, 8, 32'h80FF7F01);
    add("sb_21",   OP_SB,  32'h21, 32'h000000AB, 32'h0, 1'b0, 4, 1, 8, 32'h80AB7F01);
    add("sh_22",   OP_SH,  32'h22, 32'hFFFF1234, 32'h0, 1'b0, 4, 1, 8, 32'h80AB1234);
    add("sb_20",   OP_SB,  32'h20, 32'hCCCCCC5A, 32'h0, 1'b0, 4, 1, 8, 32'h5AAB1234);
    add("lw_22",   OP_LW,  32'h22, 32'h0, TRAP ? 32'h0 : 32'h5AAB1234, TRAP, TRAP ? 1 : 3, 0, 8, 32'h5AAB1234);
    add("lh_23",   OP_LH,  32'h23, 32'h0, TRAP ? 32'h0 : 32'h00001234, TRAP, TRAP ? 1 : 3, 0, 8, 32'h5AAB1234);
    add("sw_40",   OP_SW,  32'h40, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1, 16, 32'hCAFEF00D);
    add("sbu_43",  OP_SBU, 32'h43, 32'h00000077, 32'h0, 1'b0, 4, 1, 16, 32'hCAFEF077);
    add("lhu_40",  OP_LHU, 32'h40, 32'h0, 32'h0000CAFE, 1'b0, 3, 0, 16, 32'hCAFEF077);
    add("lh_40",   OP_LH,  32'h40, 32'h0, 32'hFFFFCAFE, 1'b0, 3, 0, 16, 32'hCAFEF077);
    add("lw3_40",  OP_LW3, 32'h40, 32'h0, 32'hCAFEF077, 1'b0, 3, 0, 16, 32'hCAFEF077);
    add("lwu_40",  OP_LWU, 32'h40, 32'h0, 32'hCAFEF077, 1'b0, 3, 0, 16, 32'hCAFEF077);
    add("sh_41",   OP_SH,  32'h41, 32'h0000BEEF, 32'h0, TRAP, TRAP ? 1 : 4, TRAP ? 0 : 1, 16,
        TRAP ? 32'hCAFEF077 : 32'hBEEFF077);
    add("sw_45",   OP_SW,  32'h45, 32'h01020304, 32'h0, TRAP, TRAP ? 1 : 2, TRAP ? 0 : 1, 17,
        TRAP ? 32'h00000000 : 32'h01020304);

    foreach (vecs[i]) begin
      run_txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, rd, er, lat, wec, pa);
      check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
      check({vecs[i].name, "_err"},   32'(er), 32'(vecs[i].exp_err));
      check({vecs[i].name, "_lat"},   32'(lat), 32'(vecs[i].exp_lat));
      check({vecs[i].name, "_we"},    32'(wec), 32'(vecs[i].exp_we));
      check({vecs[i].name, "_pulse"}, 32'(pa), 32'd0);
      check({vecs[i].name, "_word"},  mem[vecs[i].widx], vecs[i].exp_word);
    end

    // Reset during CAP of a byte store: no write, no response
    req_valid = 1'b1; req_op = OP_SB; req_addr = 32'h21; req_wdata = 32'h000000EE;
    step();
    req_valid = 1'b0;
    check("abort_cap_busy", 32'(req_ready), 32'd0);
    step();
    seen_we = 1'b0; seen_rsp = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_cap_ready", 32'(req_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      seen_we |= mem_we; seen_rsp |= rsp_valid;
      step();
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      seen_we |= mem_we; seen_rsp |= rsp_valid;
      step();
    end
    check("abort_cap_we",    32'(seen_we), 32'd0);
    check("abort_cap_rsp",   32'(seen_rsp), 32'd0);
    check("abort_cap_word",  mem[8], 32'h5AAB1234);
    check("abort_cap_ready2", 32'(req_ready), 32'd1);

    // Reset while mem_we is high: write enable must drop at once
    req_valid = 1'b1; req_op = OP_SB; req_addr = 32'h20; req_wdata = 32'h00000011;
    step();
    req_valid = 1'b0;
    step();
    step();
    check("abort_wr_we_hi", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_wr_we_lo", 32'(mem_we), 32'd0);
    step();
    step();
    check("abort_wr_word", mem[8], 32'h5AAB1234);
    check("abort_wr_rsp",  32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    step();

    // Back-to-back: LW accepted in the SW response cycle
    req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h30; req_wdata = 32'hDEADBEEF;
    step();
    req_op = OP_LW; req_wdata = 32'h0;
    check("b2b_busy",      32'(req_ready), 32'd0);
    step();
    check("b2b_sw_rsp",    32'(rsp_valid), 32'd1);
    check("b2b_sw_ready",  32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    check("b2b_lw_accept", 32'(req_ready), 32'd0);
    check("b2b_no_rsp1",   32'(rsp_valid), 32'd0);
    step();
    check("b2b_no_rsp2",   32'(rsp_valid), 32'd0);
    step();
    check("b2b_lw_rsp",    32'(rsp_valid), 32'd1);
    check("b2b_lw_rdata",  rsp_rdata, 32'hDEADBEEF);
    check("b2b_word",      mem[12], 32'hDEADBEEF);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front-end for the MIPS CPU memory stage, placed directly upstream of `datamemory`. It takes one load or store request per transaction from the execute/memory pipeline register and converts byte or halfword accesses into word accesses on the word-only data memory. Sub-word stores use a read-modify-write sequence. Load results are extracted and sign- or zero-extended, and each transaction ends with a single-cycle response pulse.

## Interface
- `MEM_AW`, default 8: word-address width toward `datamemory`. `mem_addr = req_addr[MEM_AW+1:2]`; higher address bits are ignored.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; a request is accepted on an edge where `req_valid && req_ready`.
- `req_op`  in  4  `{store, unsigned, size[1:0]}`; size 00 = byte, 01 = half, 10 = word. Size 11 is treated as word.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  32  load result; 0 for stores.
- `rsp_err`  out  1  misaligned access; valid together with `rsp_valid`.
- `mem_addr`  out  MEM_AW  word address to `datamemory`.
- `mem_wdata`  out  32  write word.
- `mem_we`  out  1  write enable.
- `mem_rdata`  in  32  `datamemory` read data, valid one cycle after `mem_addr` is presented.

## Operation
- Byte order is big-endian. Byte offset 0 is bits [31:24]. Halfword offset 0 is bits [31:16].
- The FSM has four states: IDLE, RD, CAP, WR.
- IDLE on accept:
  - LW/LB/LH/LBU/LHU go to RD.
  - SW goes to WR.
  - SB/SH go to RD.
  - Request fields are latched on accept.
- RD: `mem_addr` is stable and `mem_we` = 0. Next state is CAP.
- CAP: `mem_rdata` is valid.
  - Loads: extract the addressed lane, then sign-extend, or zero-extend when `unsigned` = 1. Register the result into `rsp_rdata` and go to IDLE.
  - Sub-word stores: merge the low byte or half of the latched `wdata` into the addressed lane and register it into `mem_wdata`. Go to WR.
- WR: `mem_we` = 1 for exactly this one cycle. Next state is IDLE.
- `rsp_valid` pulses in the cycle after the transaction's final edge. `req_ready` is high in that same cycle, so back-to-back acceptance is legal.
- `mem_addr`, `mem_wdata` and `mem_we` are registered outputs.
- The `unsigned` bit is ignored for stores and for word loads.

## Timing
Edge E0 is the accept edge.
- LW/LB/LH/LBU/LHU: RD after E0, CAP after E1. `rsp_valid` is high in the cycle after E2.
- SW: WR after E0; the memory writes at E1. `rsp_valid` is high in the cycle after E1.
- SB/SH: RD after E0, CAP after E1, WR after E2; the memory writes at E3. `rsp_valid` is high in the cycle after E3.
- Reset values: state IDLE, `req_ready` = 1, and `rsp_valid`, `rsp_rdata`, `rsp_err`, `mem_addr`, `mem_wdata`, `mem_we` all 0.
- Reset asserted mid-transaction aborts it immediately:
  - `mem_we` drops asynchronously, so no partial write occurs.
  - No response is issued.
  - The memory word is unchanged if reset asserts before E3 of an RMW.
- Requests presented while `req_ready` = 0 are ignored, not queued.

## Configuration
- `MEM_ACCESS_MISALIGN_TRAP_EN` defined:
  - A halfword with `addr[0]` = 1, or a word with `addr[1:0]` ≠ 0, goes from IDLE straight back to IDLE.
  - `rsp_valid` = 1 and `rsp_err` = 1 in the cycle after E0, with `rsp_rdata` = 0.
  - No memory access is made and `mem_we` never asserts.
- Not defined:
  - Misaligned low bits are forced to zero (half uses `addr & ~1`, word uses `addr & ~3`), and the access proceeds normally.
  - `rsp_err` is tied to 0.

## Structure
- Shared package `mem_access_pkg` holds:
  - the op field bit positions,
  - the size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`,
  - the state enumeration.
- One sub-module, `mem_lane_align`, which is purely combinational. It covers both directions:
  - lane extraction with sign/zero extension for loads;
  - lane merge for stores, given offset, size and unsigned.
- The FSM and all registers live in `mem_access_unit`.

## Test plan
- Preload word address 4 with 0x11223344; LW at 0x10 → `rsp_rdata` = 0x11223344, `rsp_valid` in the cycle after E2, `mem_we` never high.
- Word address 8 = 0x80FF7F01:
  - LB 0x20 → 0xFFFFFF80
  - LBU 0x20 → 0x00000080
  - LH 0x20 → 0xFFFF80FF
  - LHU 0x22 → 0x00007F01
- On that word, SB 0x21 with `wdata` 0x000000AB → word becomes 0x80AB7F01. Then SH 0x22 with 0x00001234 → 0x80AB1234. `mem_we` is high for exactly one cycle per store.
- LW 0x22:
  - With the macro: `rsp_err` = 1 one cycle after accept, no memory access.
  - Without it: returns the word at 0x20 and `rsp_err` = 0.
- SB 0x21 issued, then `rst_n` pulled low during CAP → `mem_we` never pulses, the word is unchanged, and `req_ready` = 1 after release.
- `req_valid` held high for SW 0x30 with 0xDEADBEEF followed by LW 0x30 → the LW is accepted in the SW response cycle and returns 0xDEADBEEF.
